// File: rtl/nn_train_sequencer.sv
// Train-loop sequencer: drives the forward/training start-done handshakes and owns the live
// Q8.8 CNN parameters, looping forward -> check -> train -> commit until a stop condition.
module nn_train_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned STEP_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [15:0]       label,
    input  logic [15:0]       tolerance,
    input  logic              load_params,
    input  logic [15:0]       kernel_init [3][3],
    input  logic [15:0]       fc_w_init [4],
    input  logic [15:0]       fc_b_init,
    output logic              fwd_start,
    input  logic              fwd_done,
    input  logic [15:0]       fwd_output,
    output logic              trn_start,
    input  logic              trn_done,
    input  logic [15:0]       trn_kernel_out [3][3],
    input  logic [15:0]       trn_fc_w_out [4],
    input  logic [15:0]       trn_fc_b_out,
    output logic [15:0]       kernel_cur [3][3],
    output logic [15:0]       fc_w_cur [4],
    output logic [15:0]       fc_b_cur,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic              timed_out,
    output logic              aborted,
    output logic [STEP_W-1:0] steps_done,
    output logic [15:0]       last_error
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StFwdStart, StFwdWait, StCheck, StTrnStart, StTrnWait, StCommit, StFinish
    } state_e;

    state_e             state_q, state_d;
    logic               fwd_done_q, trn_done_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [15:0]        fwd_out_q;
    logic [STEP_W-1:0]  num_steps_q, steps_q;
    logic               converged_q, timed_out_q, aborted_q;
    logic [15:0]        last_err_q;
    logic [15:0]        kernel_q [3][3];
    logic [15:0]        fc_w_q [4];
    logic [15:0]        fc_b_q;

    logic               fwd_rise, trn_rise, wait_expired;
    logic signed [16:0] err_wide;
    logic [15:0]        err_sat, err_abs;
    logic               within_tol;
    logic               run_start, do_load, capture_fwd, store_err;
    logic               set_conv, set_timeout, set_abort, do_commit;

    assign fwd_rise     = fwd_done & ~fwd_done_q;
    assign trn_rise     = trn_done & ~trn_done_q;
    assign wait_expired = (wait_cnt_q == CNT_LAST);

    assign err_wide = $signed({label[15], label}) - $signed({fwd_out_q[15], fwd_out_q});

    // Saturate to 16 bits; abs(-32768) is clamped to 32767 so it fits the unsigned compare.
    always_comb begin
        err_sat = err_wide[15:0];
        if (err_wide[16] != err_wide[15]) begin
            err_sat = err_wide[16] ? 16'h8000 : 16'h7fff;
        end
        err_abs = err_sat;
        if (err_sat == 16'h8000) begin
            err_abs = 16'h7fff;
        end else if (err_sat[15]) begin
            err_abs = ~err_sat + 16'd1;
        end
    end

    assign within_tol = (err_abs <= tolerance);

    always_comb begin
        state_d     = state_q;
        run_start   = 1'b0;
        do_load     = 1'b0;
        capture_fwd = 1'b0;
        store_err   = 1'b0;
        set_conv    = 1'b0;
        set_timeout = 1'b0;
        set_abort   = 1'b0;
        do_commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                do_load = load_params;
                if (go) begin
                    run_start = 1'b1;
                    state_d   = StFwdStart;
                end
            end
            StFwdStart: state_d = StFwdWait;
            StFwdWait: begin
                if (fwd_rise) begin
                    capture_fwd = 1'b1;
                    state_d     = StCheck;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = StFinish;
                end
            end
            StCheck: begin
                store_err = 1'b1;
                if (within_tol) begin
                    set_conv = 1'b1;
                    state_d  = StFinish;
                end else if (steps_q == num_steps_q) begin
                    state_d = StFinish;
                end else begin
                    state_d = StTrnStart;
                end
            end
            StTrnStart: state_d = StTrnWait;
            StTrnWait: begin
                if (trn_rise) begin
                    state_d = StCommit;
                end else if (wait_expired) begin
                    set_timeout = 1'b1;
                    state_d     = StFinish;
                end
            end
            StCommit: begin
                do_commit = 1'b1;
                state_d   = StFwdStart;
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        // Abort overrides every other effect of the current cycle, including a pending commit.
        if (abort && state_q != StIdle && state_q != StFinish) begin
            state_d     = StFinish;
            set_abort   = 1'b1;
            capture_fwd = 1'b0;
            store_err   = 1'b0;
            set_conv    = 1'b0;
            set_timeout = 1'b0;
            do_commit   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fwd_done_q  <= 1'b0;
            trn_done_q  <= 1'b0;
            wait_cnt_q  <= '0;
            fwd_out_q   <= '0;
            num_steps_q <= '0;
            steps_q     <= '0;
            converged_q <= 1'b0;
            timed_out_q <= 1'b0;
            aborted_q   <= 1'b0;
            last_err_q  <= '0;
            fc_b_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    kernel_q[i][j] <= '0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                fc_w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            // Zero during START so a done level held over from before only counts after a fresh rise.
            fwd_done_q <= (state_d == StFwdStart) ? 1'b0 : fwd_done;
            trn_done_q <= (state_d == StTrnStart) ? 1'b0 : trn_done;
            if (state_q == StFwdWait || state_q == StTrnWait) begin
                wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end else begin
                wait_cnt_q <= '0;
            end
            if (capture_fwd) fwd_out_q <= fwd_output;
            if (run_start) begin
                num_steps_q <= num_steps;
                steps_q     <= '0;
                converged_q <= 1'b0;
                timed_out_q <= 1'b0;
                aborted_q   <= 1'b0;
                last_err_q  <= '0;
            end
            if (store_err)   last_err_q  <= err_sat;
            if (set_conv)    converged_q <= 1'b1;
            if (set_timeout) timed_out_q <= 1'b1;
            if (set_abort)   aborted_q   <= 1'b1;
            if (do_load) begin
                kernel_q <= kernel_init;
                fc_w_q   <= fc_w_init;
                fc_b_q   <= fc_b_init;
            end else if (do_commit) begin
                kernel_q <= trn_kernel_out;
                fc_w_q   <= trn_fc_w_out;
                fc_b_q   <= trn_fc_b_out;
                steps_q  <= steps_q + STEP_W'(1);
            end
        end
    end

    assign fwd_start  = (state_q == StFwdStart);
    assign trn_start  = (state_q == StTrnStart);
    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StFinish);
    assign converged  = converged_q;
    assign timed_out  = timed_out_q;
    assign aborted    = aborted_q;
    assign steps_done = steps_q;
    assign last_error = last_err_q;
    assign kernel_cur = kernel_q;
    assign fc_w_cur   = fc_w_q;
    assign fc_b_cur   = fc_b_q;

endmodule

// File: tb/tb_nn_train_sequencer.sv
// Directed bench for nn_train_sequencer with stub forward/training pipelines driven on negedge.
module tb_nn_train_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0, abort = 1'b0, load_params = 1'b0;
    logic [7:0]  num_steps = '0;
    logic [15:0] label = '0, tolerance = '0, fc_b_init = '0;
    logic [15:0] kernel_init [3][3];
    logic [15:0] fc_w_init [4];
    logic        fwd_start, trn_start, fwd_done = 1'b0, trn_done = 1'b0;
    logic [15:0] fwd_output = '0, trn_fc_b_out = '0;
    logic [15:0] trn_kernel_out [3][3];
    logic [15:0] trn_fc_w_out [4];
    logic [15:0] kernel_cur [3][3];
    logic [15:0] fc_w_cur [4];
    logic [15:0] fc_b_cur, last_error;
    logic        busy, done, converged, timed_out, aborted;
    logic [7:0]  steps_done;

    int checks = 0, failures = 0;
    int fwd_n = 0, trn_n = 0, done_n = 0, fwd_base = 0, trn_base = 0, done_base = 0;
    int fwd_cnt = 0, trn_cnt = 0;
    bit fwd_auto = 1, fwd_hold = 0, trn_auto = 1, trn_abort = 0;
    logic [15:0] fwd_val1 = 16'd288, fwd_val2 = 16'd288;

    nn_train_sequencer dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .num_steps(num_steps), .label(label),
        .tolerance(tolerance), .load_params(load_params), .kernel_init(kernel_init),
        .fc_w_init(fc_w_init), .fc_b_init(fc_b_init), .fwd_start(fwd_start),
        .fwd_done(fwd_done), .fwd_output(fwd_output), .trn_start(trn_start),
        .trn_done(trn_done), .trn_kernel_out(trn_kernel_out), .trn_fc_w_out(trn_fc_w_out),
        .trn_fc_b_out(trn_fc_b_out), .kernel_cur(kernel_cur), .fc_w_cur(fc_w_cur),
        .fc_b_cur(fc_b_cur), .busy(busy), .done(done), .converged(converged),
        .timed_out(timed_out), .aborted(aborted), .steps_done(steps_done),
        .last_error(last_error)
    );

    always #5 clk = ~clk;

    // Forward stub: done pulse 5 cycles after start; second and later passes return fwd_val2.
    always @(negedge clk) begin
        bit pulse;
        pulse = 0;
        if (fwd_start) begin
            fwd_n++;
            fwd_cnt = 5;
        end else if (fwd_cnt != 0) begin
            fwd_cnt--;
            if (fwd_cnt == 0) pulse = 1;
        end
        fwd_done   = fwd_hold | (fwd_auto & pulse);
        fwd_output = ((fwd_n - fwd_base) >= 2) ? fwd_val2 : fwd_val1;
    end

    // Training stub: returns kernel+1, fc_w+2, bias+3 seven cycles after start.
    always @(negedge clk) begin
        bit pulse;
        pulse = 0;
        if (trn_start) begin
            trn_n++;
            trn_cnt = 7;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) trn_kernel_out[i][j] = kernel_cur[i][j] + 16'd1;
            for (int i = 0; i < 4; i++) trn_fc_w_out[i] = fc_w_cur[i] + 16'd2;
            trn_fc_b_out = fc_b_cur + 16'd3;
        end else if (trn_cnt != 0) begin
            trn_cnt--;
            if (trn_cnt == 0) pulse = 1;
        end
        trn_done = trn_auto & pulse;
        abort    = trn_auto & trn_abort & pulse;
    end

    always @(negedge clk) if (done === 1'b1) done_n++;

    function automatic bit kern_is(input logic [15:0] v);
        bit ok = 1;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) if (kernel_cur[i][j] !== v) ok = 0;
        return ok;
    endfunction

    function automatic bit fcw_is(input logic [15:0] v);
        bit ok = 1;
        for (int i = 0; i < 4; i++) if (fc_w_cur[i] !== v) ok = 0;
        return ok;
    endfunction

    function automatic bit outputs_zero();
        bit z = kern_is(16'd0) & fcw_is(16'd0);
        if (fc_b_cur !== 0 || fwd_start !== 0 || trn_start !== 0 || busy !== 0 || done !== 0 ||
            converged !== 0 || timed_out !== 0 || aborted !== 0 || steps_done !== 0 ||
            last_error !== 0) z = 0;
        return z;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input bit load, input logic [15:0] k, input logic [15:0] w,
                             input logic [15:0] b, input logic [15:0] lbl,
                             input logic [15:0] tol, input logic [7:0] steps);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) kernel_init[i][j] = k;
        for (int i = 0; i < 4; i++) fc_w_init[i] = w;
        fc_b_init = b; label = lbl; tolerance = tol; num_steps = steps;
        fwd_base = fwd_n; trn_base = trn_n; done_base = done_n;
        load_params = load; go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; load_params = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1;
        end
    endtask

    task automatic wait_trn_start(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            if (trn_start === 1'b1) seen = 1;
        end
    endtask

    task automatic test_reset;
        bit seen;
        rst = 1'b1;
        idle(3);
        checks++; if (!outputs_zero()) begin failures++; $display("FAIL reset.outputs got=nonzero exp=all_zero"); end
        rst = 1'b0;
        idle(2);
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd3);
        wait_trn_start(100, seen);
        checks++; if (!seen) begin failures++; $display("FAIL reset.trn_start got=none exp=pulse"); end
        idle(3);
        checks++; if (kernel_cur[0][0] !== 16'd64 || busy !== 1'b1) begin failures++; $display("FAIL reset.pre got=k%0d busy%0d exp=k64 busy1", kernel_cur[0][0], busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (!outputs_zero()) begin failures++; $display("FAIL reset.async got=nonzero exp=all_zero busy=%0d", busy); end
        idle(2);
        rst = 1'b0;
        trn_base = trn_n;
        idle(30);
        checks++; if (trn_n - trn_base != 0 || busy !== 1'b0) begin failures++; $display("FAIL reset.after got=trn%0d busy%0d exp=trn0 busy0", trn_n - trn_base, busy); end
    endtask

    task automatic test_full_budget;
        bit seen;
        fwd_val1 = 16'd288; fwd_val2 = 16'd288;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd3);
        wait_done(400, seen);
        checks++; if (!seen) begin failures++; $display("FAIL full.done got=none exp=pulse"); end
        checks++; if (fwd_n - fwd_base != 4 || trn_n - trn_base != 3) begin failures++; $display("FAIL full.starts got=fwd%0d trn%0d exp=fwd4 trn3", fwd_n - fwd_base, trn_n - trn_base); end
        checks++; if (!kern_is(16'd67) || !fcw_is(16'd134) || fc_b_cur !== 16'd9) begin failures++; $display("FAIL full.params got=%0d/%0d/%0d exp=67/134/9", kernel_cur[0][0], fc_w_cur[0], fc_b_cur); end
        checks++; if (steps_done !== 8'd3) begin failures++; $display("FAIL full.steps got=%0d exp=3", steps_done); end
        checks++; if (last_error !== 16'd224) begin failures++; $display("FAIL full.error got=%0d exp=224", last_error); end
        checks++; if (converged !== 1'b0 || timed_out !== 1'b0 || aborted !== 1'b0) begin failures++; $display("FAIL full.flags got=%0d%0d%0d exp=000", converged, timed_out, aborted); end
        idle(12);
        checks++; if (done_n - done_base != 1 || busy !== 1'b0) begin failures++; $display("FAIL full.single_done got=%0d busy%0d exp=1 busy0", done_n - done_base, busy); end
    endtask

    task automatic test_converge;
        bit seen;
        fwd_val1 = 16'd288; fwd_val2 = 16'd500;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd16, 8'd3);
        wait_done(400, seen);
        idle(12);
        checks++; if (!seen) begin failures++; $display("FAIL conv.done got=none exp=pulse"); end
        checks++; if (converged !== 1'b1 || steps_done !== 8'd1) begin failures++; $display("FAIL conv.state got=c%0d s%0d exp=c1 s1", converged, steps_done); end
        checks++; if (last_error !== 16'd12) begin failures++; $display("FAIL conv.error got=%0d exp=12", last_error); end
        checks++; if (trn_n - trn_base != 1 || fwd_n - fwd_base != 2) begin failures++; $display("FAIL conv.starts got=trn%0d fwd%0d exp=trn1 fwd2", trn_n - trn_base, fwd_n - fwd_base); end
        checks++; if (!kern_is(16'd65) || !fcw_is(16'd130) || fc_b_cur !== 16'd3) begin failures++; $display("FAIL conv.params got=%0d/%0d/%0d exp=65/130/3", kernel_cur[0][0], fc_w_cur[0], fc_b_cur); end
        fwd_val2 = 16'd288;
    endtask

    task automatic test_timeout;
        bit seen, early;
        trn_auto = 0;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd2);
        wait_trn_start(100, seen);
        checks++; if (!seen) begin failures++; $display("FAIL tmo.trn_start got=none exp=pulse"); end
        @(posedge clk); #1;
        early = 0;
        repeat (1023) begin
            @(posedge clk); #1;
            if (timed_out !== 1'b0 || busy !== 1'b1) early = 1;
        end
        checks++; if (early) begin failures++; $display("FAIL tmo.early got=timed_out_before_1024 exp=none"); end
        @(posedge clk); #1;
        checks++; if (timed_out !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL tmo.at_1024 got=t%0d d%0d exp=t1 d1", timed_out, done); end
        checks++; if (!kern_is(16'd64) || !fcw_is(16'd128) || fc_b_cur !== 16'd0 || steps_done !== 8'd0) begin failures++; $display("FAIL tmo.params got=%0d/%0d/%0d s%0d exp=64/128/0 s0", kernel_cur[0][0], fc_w_cur[0], fc_b_cur, steps_done); end
        trn_auto = 1;
        idle(12);
    endtask

    task automatic test_zero_steps;
        bit seen;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd0);
        wait_done(100, seen);
        idle(12);
        checks++; if (!seen) begin failures++; $display("FAIL zero.done got=none exp=pulse"); end
        checks++; if (fwd_n - fwd_base != 1 || trn_n - trn_base != 0) begin failures++; $display("FAIL zero.starts got=fwd%0d trn%0d exp=fwd1 trn0", fwd_n - fwd_base, trn_n - trn_base); end
        checks++; if (steps_done !== 8'd0 || last_error !== 16'd224 || converged !== 1'b0 || timed_out !== 1'b0) begin failures++; $display("FAIL zero.status got=s%0d e%0d c%0d t%0d exp=s0 e224 c0 t0", steps_done, last_error, converged, timed_out); end
    endtask

    task automatic test_busy_ignore;
        bit seen;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd1);
        idle(3);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) kernel_init[i][j] = 16'd999;
        for (int i = 0; i < 4; i++) fc_w_init[i] = 16'd999;
        fc_b_init = 16'd999; num_steps = 8'd0;
        go = 1'b1; load_params = 1'b1;
        @(posedge clk); #1;
        go = 1'b0; load_params = 1'b0;
        checks++; if (!kern_is(16'd64)) begin failures++; $display("FAIL ignore.load got=%0d exp=64", kernel_cur[0][0]); end
        wait_done(200, seen);
        idle(12);
        checks++; if (!seen || steps_done !== 8'd1) begin failures++; $display("FAIL ignore.steps got=%0d seen%0d exp=1", steps_done, seen); end
        checks++; if (!kern_is(16'd65) || !fcw_is(16'd130) || fc_b_cur !== 16'd3) begin failures++; $display("FAIL ignore.params got=%0d/%0d/%0d exp=65/130/3", kernel_cur[0][0], fc_w_cur[0], fc_b_cur); end
        checks++; if (done_n - done_base != 1 || busy !== 1'b0) begin failures++; $display("FAIL ignore.done got=%0d busy%0d exp=1 busy0", done_n - done_base, busy); end
    endtask

    task automatic test_abort;
        bit seen;
        trn_abort = 1;
        start_run(1, 16'd64, 16'd128, 16'd0, 16'd512, 16'd0, 8'd3);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            if (aborted === 1'b1) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL abort.flag got=0 exp=1"); end
        checks++; if (done !== 1'b1 || trn_done !== 1'b1) begin failures++; $display("FAIL abort.timing got=done%0d trn_done%0d exp=1 1", done, trn_done); end
        checks++; if (steps_done !== 8'd0 || !kern_is(16'd64) || fc_b_cur !== 16'd0 || converged !== 1'b0) begin failures++; $display("FAIL abort.no_commit got=s%0d k%0d b%0d exp=s0 k64 b0", steps_done, kernel_cur[0][0], fc_b_cur); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort.end got=done%0d busy%0d exp=0 0", done, busy); end
        trn_abort = 0;
        idle(12);
    endtask

    task automatic test_level_held;
        bit seen;
        fwd_auto = 0; fwd_hold = 1;
        fwd_val1 = 16'h8000;
        idle(3);
        start_run(0, 16'd0, 16'd0, 16'd0, 16'h7f00, 16'd0, 8'd0);
        idle(10);
        checks++; if (busy !== 1'b1 || done_n - done_base != 0 || fwd_n - fwd_base != 1) begin failures++; $display("FAIL held.ignored got=busy%0d done%0d exp=busy1 done0", busy, done_n - done_base); end
        checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL held.cleared got=%0d exp=0", aborted); end
        fwd_hold = 0;
        idle(2);
        fwd_hold = 1;
        idle(1);
        fwd_hold = 0;
        wait_done(20, seen);
        checks++; if (!seen) begin failures++; $display("FAIL held.done got=none exp=pulse"); end
        checks++; if (last_error !== 16'h7fff || converged !== 1'b0) begin failures++; $display("FAIL held.sat_pos got=%h c%0d exp=7fff c0", last_error, converged); end
        fwd_auto = 1;
        idle(12);
    endtask

    task automatic test_saturation;
        bit seen;
        fwd_val1 = 16'h7fff;
        start_run(0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h7fff, 8'd0);
        wait_done(100, seen);
        checks++; if (!seen || last_error !== 16'h8000 || converged !== 1'b1) begin failures++; $display("FAIL sat.neg_eq got=%h c%0d exp=8000 c1", last_error, converged); end
        idle(12);
        start_run(0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h7ffe, 8'd0);
        wait_done(100, seen);
        checks++; if (!seen || last_error !== 16'h8000 || converged !== 1'b0) begin failures++; $display("FAIL sat.neg_below got=%h c%0d exp=8000 c0", last_error, converged); end
        idle(12);
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) kernel_init[i][j] = '0;
        for (int i = 0; i < 4; i++) fc_w_init[i] = '0;
        test_reset();
        test_full_budget();
        test_converge();
        test_timeout();
        test_zero_steps();
        test_busy_ignore();
        test_abort();
        test_level_held();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
